axil_slave_demux: RTL and testbench

Single AXI-Lite slave port fanned out to NUM_SLAVES AXI-Lite master ports, decoded on address bits. It replaces the per-slave I2C bridge arrangement (one bridge, one I2C device address per slave) with one bridge feeding this demux. Adds per-transaction timeout, error responses and drain of late responses, so a hung slave cannot lock the management bus.

---
 rtl/axil_slave_demux.sv | 249 ++++++++++++++++++++++++
 tb/tb_axil_slave_demux.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_demux.sv
// AXI-Lite 1:N demux decoded on addr[SEL_LSB +: SEL_BITS]. One transaction in flight;
// a per-transaction timeout abandons hung slaves and late responses are drained.
module axil_slave_demux #(
  parameter  int NUM_SLAVES = 8,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int SEL_LSB    = 24,
  parameter  int TIMEOUT    = 1024,
  localparam int SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [NUM_SLAVES-1:0]            m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_awready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_wdata,
  output logic [NUM_SLAVES*STRB_WIDTH-1:0] m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]            m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_wready,
  input  logic [NUM_SLAVES*2-1:0]          m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_bready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [NUM_SLAVES-1:0]            m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_arready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [NUM_SLAVES*2-1:0]          m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_rready,
  output logic [15:0]                      timeout_count,
  output logic [NUM_SLAVES-1:0]            drain_pending
);

  localparam int             TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]     SLVERR   = 2'b10;
  localparam logic [1:0]     DECERR   = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_FWD, WR_RESP, RD_FWD, RD_RESP, ERR_RESP} state_e;

  state_e                state_q, state_d;
  logic                  grant_wr_q, grant_rd_q, prio_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [SEL_BITS-1:0]   idx_q, sel_in;
  logic                  aw_done_q, w_done_q, ar_done_q, err_rd_q;
  logic [TW-1:0]         tmo_q;
  logic [1:0]            resp_q;

  logic                  wr_elig, rd_elig, pick_wr, pick_rd, idle_free;
  logic                  accept_wr, accept_rd, accept, dec_err, dec_busy;
  logic                  tmo_hit, b_hs, r_hs, abandon, fwd_acc;
  logic                  sel_awready, sel_wready, sel_arready, sel_bvalid, sel_rvalid;
  logic [1:0]            sel_bresp, sel_rresp;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [NUM_SLAVES-1:0] drain_set, drain_clr;

  // Upstream arbitration: a grant is registered first, then the handshake completes.
  assign wr_elig   = s_axi_awvalid && s_axi_wvalid;
  assign rd_elig   = s_axi_arvalid;
  assign pick_wr   = wr_elig && (!rd_elig || prio_wr_q);
  assign pick_rd   = rd_elig && !pick_wr;
  assign idle_free = (state_q == IDLE) && !grant_wr_q && !grant_rd_q;
  assign accept_wr = grant_wr_q && wr_elig;
  assign accept_rd = grant_rd_q && rd_elig;
  assign accept    = accept_wr || accept_rd;
  assign sel_in    = grant_wr_q ? s_axi_awaddr[SEL_LSB +: SEL_BITS]
                                : s_axi_araddr[SEL_LSB +: SEL_BITS];
  assign dec_err   = int'(sel_in) >= NUM_SLAVES;
  assign tmo_hit   = (tmo_q == TMO_LAST);

  assign s_axi_awready = grant_wr_q;
  assign s_axi_wready  = grant_wr_q;
  assign s_axi_arready = grant_rd_q;
  assign s_axi_bvalid  = (state_q == WR_RESP) || (state_q == ERR_RESP && !err_rd_q);
  assign s_axi_rvalid  = (state_q == RD_RESP) || (state_q == ERR_RESP && err_rd_q);
  assign s_axi_bresp   = resp_q;
  assign s_axi_rresp   = resp_q;
  assign s_axi_rdata   = rdata_q;

  assign m_axi_awaddr  = {NUM_SLAVES{addr_q}};
  assign m_axi_araddr  = {NUM_SLAVES{addr_q}};
  assign m_axi_wdata   = {NUM_SLAVES{wdata_q}};
  assign m_axi_wstrb   = {NUM_SLAVES{wstrb_q}};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_arready = 1'b0;
    sel_bvalid  = 1'b0;
    sel_rvalid  = 1'b0;
    sel_bresp   = 2'b00;
    sel_rresp   = 2'b00;
    sel_rdata   = '0;
    dec_busy    = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_awready = m_axi_awready[i];
        sel_wready  = m_axi_wready[i];
        sel_arready = m_axi_arready[i];
        sel_bvalid  = m_axi_bvalid[i];
        sel_rvalid  = m_axi_rvalid[i];
        sel_bresp   = m_axi_bresp[2*i +: 2];
        sel_rresp   = m_axi_rresp[2*i +: 2];
        sel_rdata   = m_axi_rdata[DATA_WIDTH*i +: DATA_WIDTH];
      end
      if (sel_in == SEL_BITS'(i)) dec_busy = drain_pending[i];
    end
  end

  assign b_hs    = (state_q == WR_FWD) && aw_done_q && w_done_q && sel_bvalid;
  assign r_hs    = (state_q == RD_FWD) && ar_done_q && sel_rvalid;
  assign abandon = tmo_hit && (((state_q == WR_FWD) && !b_hs) || ((state_q == RD_FWD) && !r_hs));
  // The slave owes a response only once it has taken the address.
  assign fwd_acc = (state_q == WR_FWD) ? (aw_done_q || sel_awready) : (ar_done_q || sel_arready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = (dec_err || dec_busy) ? ERR_RESP
                                    : (accept_wr ? WR_FWD : RD_FWD);
      WR_FWD:   if (b_hs) state_d = WR_RESP;
                else if (abandon) state_d = ERR_RESP;
      WR_RESP:  if (s_axi_bready) state_d = IDLE;
      RD_FWD:   if (r_hs) state_d = RD_RESP;
                else if (abandon) state_d = ERR_RESP;
      RD_RESP:  if (s_axi_rready) state_d = IDLE;
      ERR_RESP: if (err_rd_q ? s_axi_rready : s_axi_bready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = '0;
    m_axi_wvalid  = '0;
    m_axi_bready  = '0;
    m_axi_arvalid = '0;
    m_axi_rready  = '0;
    drain_set     = '0;
    drain_clr     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        m_axi_awvalid[i] = (state_q == WR_FWD) && !aw_done_q;
        m_axi_wvalid[i]  = (state_q == WR_FWD) && !w_done_q;
        m_axi_bready[i]  = (state_q == WR_FWD) && aw_done_q && w_done_q;
        m_axi_arvalid[i] = (state_q == RD_FWD) && !ar_done_q;
        m_axi_rready[i]  = (state_q == RD_FWD) && ar_done_q;
        drain_set[i]     = abandon && fwd_acc;
      end
      // A draining slot accepts and discards whatever response arrives late.
      if (drain_pending[i]) begin
        m_axi_bready[i] = 1'b1;
        m_axi_rready[i] = 1'b1;
        drain_clr[i]    = m_axi_bvalid[i] || m_axi_rvalid[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, so s_axi_rdata/resp read as zero out of reset.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      grant_wr_q    <= 1'b0;
      grant_rd_q    <= 1'b0;
      prio_wr_q     <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      idx_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      ar_done_q     <= 1'b0;
      err_rd_q      <= 1'b0;
      tmo_q         <= '0;
      resp_q        <= 2'b00;
      timeout_count <= '0;
      drain_pending <= '0;
    end else begin
      grant_wr_q    <= idle_free && pick_wr;
      grant_rd_q    <= idle_free && pick_rd;
      drain_pending <= (drain_pending & ~drain_clr) | drain_set;
      if (state_q == WR_FWD) begin
        tmo_q     <= tmo_q + 1'b1;
        aw_done_q <= aw_done_q || sel_awready;
        w_done_q  <= w_done_q || sel_wready;
      end
      if (state_q == RD_FWD) begin
        tmo_q     <= tmo_q + 1'b1;
        ar_done_q <= ar_done_q || sel_arready;
      end
      if (accept) begin
        prio_wr_q <= !prio_wr_q;
        idx_q     <= sel_in;
        err_rd_q  <= accept_rd;
        tmo_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        ar_done_q <= 1'b0;
        if (accept_wr) begin
          addr_q  <= s_axi_awaddr;
          wdata_q <= s_axi_wdata;
          wstrb_q <= s_axi_wstrb;
        end else begin
          addr_q  <= s_axi_araddr;
        end
        if (dec_err)       resp_q <= DECERR;
        else if (dec_busy) resp_q <= SLVERR;
        if (accept_rd && (dec_err || dec_busy)) rdata_q <= '1;
      end
      if (b_hs) resp_q <= sel_bresp;
      if (r_hs) begin
        resp_q  <= sel_rresp;
        rdata_q <= sel_rdata;
      end
      if (abandon) begin
        resp_q <= SLVERR;
        if (state_q == RD_FWD) rdata_q <= '1;
        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_demux.sv
// Directed bench for axil_slave_demux (6 slots, TIMEOUT=16) with a simple per-slot
// slave model whose latency, hang and address-stall behaviour are set per test.
module tb_axil_slave_demux;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk, rst_n;
  logic [AW-1:0]   s_axi_awaddr, s_axi_araddr;
  logic            s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0]   s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic [1:0]      s_axi_bresp, s_axi_rresp;
  logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic            s_axi_rvalid, s_axi_rready;
  logic [N*AW-1:0]     m_axi_awaddr, m_axi_araddr;
  logic [N*DW-1:0]     m_axi_wdata, m_axi_rdata;
  logic [N*(DW/8)-1:0] m_axi_wstrb;
  logic [N*2-1:0]      m_axi_bresp, m_axi_rresp;
  logic [N-1:0] m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [N-1:0] m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [N-1:0] m_axi_rvalid, m_axi_rready;
  logic [15:0]  timeout_count;
  logic [N-1:0] drain_pending;

  axil_slave_demux #(.NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .SEL_LSB(24), .TIMEOUT(16)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .timeout_count(timeout_count), .drain_pending(drain_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: address/data accepted when valid unless stalled; response after lat cycles.
  logic [N-1:0] hang, no_rdy, wa_got, wd_got, ra_got, bv, rv;
  int           lat [N];
  int           cnt [N];
  logic [DW-1:0] rdat [N];

  assign m_axi_awready = m_axi_awvalid & ~no_rdy;
  assign m_axi_wready  = m_axi_wvalid & ~no_rdy;
  assign m_axi_arready = m_axi_arvalid & ~no_rdy;
  assign m_axi_bvalid  = bv;
  assign m_axi_rvalid  = rv;
  assign m_axi_bresp   = '0;
  assign m_axi_rresp   = '0;

  always_comb begin
    m_axi_rdata = '0;
    for (int i = 0; i < N; i++) m_axi_rdata[i*DW +: DW] = rdat[i];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_got <= '0; wd_got <= '0; ra_got <= '0; bv <= '0; rv <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_axi_awvalid[i] && m_axi_awready[i]) wa_got[i] <= 1'b1;
        if (m_axi_wvalid[i] && m_axi_wready[i])   wd_got[i] <= 1'b1;
        if (m_axi_arvalid[i] && m_axi_arready[i]) ra_got[i] <= 1'b1;
        if (bv[i]) begin
          if (m_axi_bready[i]) begin bv[i] <= 1'b0; wa_got[i] <= 1'b0; wd_got[i] <= 1'b0; end
        end else if (wa_got[i] && wd_got[i] && !hang[i]) begin
          if (cnt[i] >= lat[i]) begin bv[i] <= 1'b1; cnt[i] <= 0; end
          else cnt[i] <= cnt[i] + 1;
        end
        if (rv[i]) begin
          if (m_axi_rready[i]) begin rv[i] <= 1'b0; ra_got[i] <= 1'b0; end
        end else if (ra_got[i] && !hang[i]) begin
          if (cnt[i] >= lat[i]) begin rv[i] <= 1'b1; cnt[i] <= 0; end
          else cnt[i] <= cnt[i] + 1;
        end
      end
    end
  end

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           first_mb = -1;
  int           first_mr = -1;
  logic [N-1:0] touched;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    touched |= m_axi_awvalid | m_axi_wvalid | m_axi_arvalid;
    if (first_mb < 0 && |m_axi_bvalid) first_mb = cyc;
    if (first_mr < 0 && |m_axi_rvalid) first_mr = cyc;
  endtask

  // Returns on the first negedge after the upstream handshake.
  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!s_axi_awready && n < 20) begin step(); n++; end
    check("aw_grant", s_axi_awready, 1'b1);
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic issue_rd(input logic [31:0] a);
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin step(); n++; end
    check("ar_grant", s_axi_arready, 1'b1);
    step();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output int waited, output int at);
    waited = 0;
    while (!s_axi_bvalid && waited < 200) begin step(); waited++; end
    check("b_seen", s_axi_bvalid, 1'b1);
    resp = s_axi_bresp; at = cyc;
    step();
  endtask

  task automatic wait_r(output logic [1:0] resp, output logic [31:0] data, output int at);
    int waited = 0;
    while (!s_axi_rvalid && waited < 200) begin step(); waited++; end
    check("r_seen", s_axi_rvalid, 1'b1);
    resp = s_axi_rresp; data = s_axi_rdata; at = cyc;
    step();
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          waited, at;
    logic        got_wr, sbv;
    logic        exp_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    hang = '0; no_rdy = '0; touched = '0;
    for (int i = 0; i < N; i++) begin lat[i] = 1; rdat[i] = 32'h0; end
    lat[3] = 0; lat[5] = 7; lat[2] = 2; rdat[5] = 32'h1234_5678;

    // Reset state, with upstream requests held to prove no grant appears.
    repeat (3) step();
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_bvalid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
    check("rst_tmo", timeout_count, 16'h0);
    check("rst_drain", drain_pending, 6'h0);
    check("rst_mvalid", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | m_axi_bready | m_axi_rready, 6'h0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    rst_n = 1'b1;
    step();

    // Write to slave 3, immediate ready.
    touched = '0; first_mb = -1;
    issue_wr(32'h0300_0010, 32'hA5A5_0001, 4'hF);
    check("wr3_awvalid", m_axi_awvalid, 6'b001000);
    check("wr3_wvalid", m_axi_wvalid, 6'b001000);
    check("wr3_awaddr", m_axi_awaddr[3*AW +: AW], 32'h0300_0010);
    check("wr3_wdata", m_axi_wdata[3*DW +: DW], 32'hA5A5_0001);
    check("wr3_wstrb", m_axi_wstrb[3*4 +: 4], 4'hF);
    wait_b(resp, waited, at);
    check("wr3_bresp", resp, 2'b00);
    check("wr3_b_latency", at - first_mb, 1);
    check("wr3_touched", touched, 6'b001000);

    // Read from slave 5, response after 7 cycles.
    touched = '0; first_mr = -1;
    issue_rd(32'h0500_0004);
    check("rd5_arvalid", m_axi_arvalid, 6'b100000);
    wait_r(resp, data, at);
    check("rd5_rdata", data, 32'h1234_5678);
    check("rd5_rresp", resp, 2'b00);
    check("rd5_r_latency", at - first_mr, 1);
    check("rd5_touched", touched, 6'b100000);

    // Index 7 is beyond the 6 slots.
    touched = '0;
    issue_rd(32'h0700_0000);
    wait_r(resp, data, at);
    check("dec_rresp", resp, 2'b11);
    check("dec_rdata", data, 32'hFFFF_FFFF);
    check("dec_touched", touched, 6'h0);

    // Slave 2 takes AW/W then never answers.
    hang[2] = 1'b1;
    issue_wr(32'h0200_0000, 32'hDEAD_0002, 4'h3);
    wait_b(resp, waited, at);
    check("tmo_bresp", resp, 2'b10);
    check("tmo_cycles", waited, 16);
    check("tmo_count", timeout_count, 16'd1);
    check("tmo_drain", drain_pending, 6'b000100);
    check("tmo_drain_bready", m_axi_bready, 6'b000100);

    touched = '0;
    issue_rd(32'h0200_0008);
    wait_r(resp, data, at);
    check("busy_rresp", resp, 2'b10);
    check("busy_rdata", data, 32'hFFFF_FFFF);
    check("busy_touched", touched, 6'h0);

    // Late bvalid from slave 2 is swallowed.
    hang[2] = 1'b0; sbv = 1'b0;
    for (int n = 0; n < 12 && drain_pending != '0; n++) begin step(); sbv |= s_axi_bvalid; end
    check("drain_cleared", drain_pending, 6'h0);
    check("drain_no_upstream", sbv, 1'b0);
    issue_wr(32'h0200_0004, 32'h0000_00C2, 4'hF);
    wait_b(resp, waited, at);
    check("wr2_after_drain", resp, 2'b00);
    check("wr2_tmo_count", timeout_count, 16'd1);

    // Six accepts so far leave priority on write: expect W, R, W, R.
    s_axi_awaddr = 32'h0100_0000; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF;
    s_axi_araddr = 32'h0400_0000;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      while (!s_axi_awready && !s_axi_arready && n < 20) begin step(); n++; end
      check("arb_seen", s_axi_awready | s_axi_arready, 1'b1);
      got_wr = s_axi_awready;
      check($sformatf("arb_grant%0d", g), got_wr, exp_wr[g]);
      step();
      if (got_wr) begin
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_b(resp, waited, at);
        if (g < 2) begin s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; end
      end else begin
        s_axi_arvalid = 1'b0;
        wait_r(resp, data, at);
        if (g < 2) s_axi_arvalid = 1'b1;
      end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;

    // Reset asserted while slot 1 stalls its address channel.
    no_rdy[1] = 1'b1;
    issue_wr(32'h0100_0020, 32'h0000_0011, 4'hF);
    repeat (3) step();
    check("mid_awvalid", m_axi_awvalid, 6'b000010);
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_awvalid", m_axi_awvalid | m_axi_wvalid, 6'h0);
    check("mrst_awready", s_axi_awready, 1'b0);
    check("mrst_tmo", timeout_count, 16'h0);
    check("mrst_bready", m_axi_bready | m_axi_rready, 6'h0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; no_rdy = '0;
    step();
    rst_n = 1'b1;
    step();
    issue_wr(32'h0100_0030, 32'h5A5A_0003, 4'hF);
    wait_b(resp, waited, at);
    check("post_rst_bresp", resp, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
